nash_byte_packer: RTL and testbench

Downstream stage of the Nash cipher core. It consumes the serial cipher output, one bit per qualified clock, and packs the bits into BYTE_W-wide words. It buffers the words in a small synchronous FIFO and presents them on a valid/ready interface to the byte-oriented transport logic. It also provides frame alignment, partial-word flush, and sticky overflow reporting.

---
 rtl/nash_byte_packer.sv | 107 ++++++++++
 tb/tb_nash_byte_packer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nash_byte_packer.sv
// Packs serial cipher bits into BYTE_W-bit words and queues them in a small FIFO with valid/ready output.
// Word visible one cycle after its last bit; words arriving at a full, non-popping FIFO are dropped (sticky overflow).
module nash_byte_packer #(
  parameter int BYTE_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MSB_FIRST  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  input  logic                          frame_start,
  input  logic                          flush,
  output logic [BYTE_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);

  localparam int CW = $clog2(BYTE_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] LAST = CW'(BYTE_W - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [BYTE_W-1:0] sr, sr_nxt, word, push_dat;
  logic [CW-1:0]     cnt, cnt_nxt, pos_cur, pos_first;
  logic              push;

  logic [BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              pop, full, accept;

  assign pos_cur   = (MSB_FIRST != 0) ? LAST - cnt : cnt;
  assign pos_first = (MSB_FIRST != 0) ? LAST : '0;

  // Unfilled positions of sr are always zero, so a flushed word is already padded.
  always_comb begin
    word     = sr;
    sr_nxt   = sr;
    cnt_nxt  = cnt;
    push     = 1'b0;
    push_dat = '0;
    if (frame_start) begin
      sr_nxt  = '0;
      cnt_nxt = '0;
      if (bit_valid) begin
        sr_nxt[pos_first] = bit_in;
        cnt_nxt           = CW'(1);
      end
    end else begin
      if (bit_valid) word[pos_cur] = bit_in;
      if ((bit_valid && cnt == LAST) || (flush && (bit_valid || cnt != '0))) begin
        push     = 1'b1;
        push_dat = word;
        sr_nxt   = '0;
        cnt_nxt  = '0;
      end else if (bit_valid) begin
        sr_nxt  = word;
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      cnt <= '0;
    end else begin
      sr  <= sr_nxt;
      cnt <= cnt_nxt;
    end
  end

  assign out_valid  = (level != '0);
  assign pop        = out_valid && out_ready;
  assign full       = (level == FULL_LVL);
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign accept     = push && (!full || pop);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (push && !accept) overflow <= 1'b1;
      case ({accept, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_nash_byte_packer.sv
// Drives an MSB-first and an LSB-first packer with identical inputs and checks both against a queue-based model.
module tb_nash_byte_packer;

  logic       clk = 1'b0;
  logic       reset, bit_in, bit_valid, frame_start, flush, out_ready;
  logic [7:0] msb_data, lsb_data;
  logic       msb_valid, lsb_valid, msb_ovf, lsb_ovf;
  logic [2:0] msb_level, lsb_level;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: pending bits in arrival order; queued words stored with arrival bit i at position i.
  bit         pend[$];
  logic [7:0] mq[$];
  bit         movf;

  always #5 clk = ~clk;

  nash_byte_packer #(.BYTE_W(8), .FIFO_DEPTH(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .flush(flush), .out_data(msb_data),
    .out_valid(msb_valid), .out_ready(out_ready), .fifo_level(msb_level),
    .overflow(msb_ovf));

  nash_byte_packer #(.BYTE_W(8), .FIFO_DEPTH(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
    .frame_start(frame_start), .flush(flush), .out_data(lsb_data),
    .out_valid(lsb_valid), .out_ready(out_ready), .fifo_level(lsb_level),
    .overflow(lsb_ovf));

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  function automatic logic [7:0] pack_pend();
    logic [7:0] w = '0;
    for (int i = 0; i < pend.size(); i++) w[i] = pend[i];
    return w;
  endfunction

  // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input bit bv, input bit b, input bit fs, input bit fl,
                      input bit rdy, input bit rst);
    bit         pop_now, have_push;
    logic [7:0] w;
    bit_valid = bv; bit_in = b; frame_start = fs; flush = fl;
    out_ready = rdy; reset = rst;
    if (rst) begin
      pend.delete(); mq.delete(); movf = 0;
    end else begin
      pop_now   = (mq.size() > 0) && rdy;
      have_push = 0;
      w         = '0;
      if (fs) begin
        pend.delete();
        if (bv) pend.push_back(b);
      end else begin
        if (bv) pend.push_back(b);
        if (pend.size() == 8 || (fl && pend.size() > 0)) begin
          w = pack_pend(); pend.delete(); have_push = 1;
        end
      end
      if (pop_now) void'(mq.pop_front());
      if (have_push) begin
        if (mq.size() < 4) mq.push_back(w);
        else movf = 1;
      end
    end
    @(posedge clk);
    #1;
    bit_valid = 0; frame_start = 0; flush = 0; reset = 0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit rdy);
    for (int i = 7; i >= 0; i--) tick(1, v[i], 0, 0, rdy, 0);
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    n_cmp++;
    if ({msb_data, msb_valid, msb_level, msb_ovf, lsb_data, lsb_valid, lsb_level, lsb_ovf} !== 26'd0) begin
      n_bad++;
      $display("FAIL reset_state: got msb %h/%b/%0d/%b lsb %h/%b/%0d/%b, want all zero",
               msb_data, msb_valid, msb_level, msb_ovf, lsb_data, lsb_valid, lsb_level, lsb_ovf);
    end
  endtask

  task automatic test_a5();
    bit bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++) tick(1, bits[i], 0, 0, 1, 0);
    n_cmp++;
    if (msb_valid !== 1'b1 || msb_data !== 8'hA5 || lsb_data !== 8'hA5) begin
      n_bad++;
      $display("FAIL a5_word: got valid=%b msb=%h lsb=%h, want 1/a5/a5", msb_valid, msb_data, lsb_data);
    end
    tick(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (msb_level !== 3'd0 || msb_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL a5_drain: got level=%0d valid=%b, want 0/0", msb_level, msb_valid);
    end
  endtask

  task automatic test_gaps();
    for (int i = 0; i < 8; i++) begin
      tick(1, (i == 7), 0, 0, 0, 0);
      if (i != 7) for (int g = 0; g < 3; g++) tick(0, 0, 0, 0, 0, 0);
    end
    n_cmp++;
    if (msb_data !== 8'h01 || lsb_data !== 8'h80 || msb_level !== 3'd1) begin
      n_bad++;
      $display("FAIL gap_word: got msb=%h lsb=%h level=%0d, want 01/80/1", msb_data, lsb_data, msb_level);
    end
    tick(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0, 0, 0);
    n_cmp++;
    if (msb_level !== 3'd0) begin
      n_bad++;
      $display("FAIL flush_partial_held: got level=%0d, want 0", msb_level);
    end
    tick(0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (msb_data !== 8'hE0 || lsb_data !== 8'h07 || msb_level !== 3'd1) begin
      n_bad++;
      $display("FAIL flush_word: got msb=%h lsb=%h level=%0d, want e0/07/1", msb_data, lsb_data, msb_level);
    end
    tick(0, 0, 0, 1, 0, 0);
    n_cmp++;
    if (msb_level !== 3'd1 || lsb_level !== 3'd1) begin
      n_bad++;
      $display("FAIL flush_empty: got level=%0d/%0d, want 1", msb_level, lsb_level);
    end
    tick(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    logic [7:0] vals[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) send_byte(vals[i], 0);
    n_cmp++;
    if (msb_level !== 3'd4 || msb_ovf !== 1'b1 || lsb_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set: got level=%0d ovf=%b/%b, want 4/1/1", msb_level, msb_ovf, lsb_ovf);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (msb_data !== vals[i] || msb_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL ovf_drain%0d: got %h valid=%b, want %h", i, msb_data, msb_valid, vals[i]);
      end
      tick(0, 0, 0, 0, 1, 0);
    end
    n_cmp++;
    if (msb_level !== 3'd0 || msb_ovf !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: got level=%0d ovf=%b, want 0/1", msb_level, msb_ovf);
    end
  endtask

  task automatic test_full_pop_and_frame();
    logic [7:0] exp[4] = '{8'h22, 8'h33, 8'h44, 8'h66};
    logic [7:0] v66 = 8'h66;
    logic [7:0] vc3 = 8'hC3;
    tick(0, 0, 0, 0, 0, 1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    for (int i = 7; i >= 1; i--) tick(1, v66[i], 0, 0, 0, 0);
    tick(1, v66[0], 0, 0, 1, 0);
    n_cmp++;
    if (msb_level !== 3'd4 || msb_ovf !== 1'b0 || msb_data !== 8'h22) begin
      n_bad++;
      $display("FAIL full_pop_push: got level=%0d ovf=%b head=%h, want 4/0/22", msb_level, msb_ovf, msb_data);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (msb_data !== exp[i]) begin
        n_bad++;
        $display("FAIL full_pop_order%0d: got %h, want %h", i, msb_data, exp[i]);
      end
      tick(0, 0, 0, 0, 1, 0);
    end
    tick(1, 1, 0, 0, 1, 0); tick(1, 0, 0, 0, 1, 0); tick(1, 1, 0, 0, 1, 0);
    tick(1, 1, 0, 0, 1, 0); tick(1, 0, 0, 0, 1, 0);
    tick(1, vc3[7], 1, 1, 1, 0);
    for (int i = 6; i >= 0; i--) tick(1, vc3[i], 0, 0, 1, 0);
    n_cmp++;
    if (msb_data !== 8'hC3 || lsb_data !== 8'hC3 || msb_level !== 3'd1) begin
      n_bad++;
      $display("FAIL frame_restart: got msb=%h lsb=%h level=%0d, want c3/c3/1", msb_data, lsb_data, msb_level);
    end
    tick(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_mid();
    send_byte(8'h5A, 0); send_byte(8'h3C, 0);
    for (int i = 0; i < 4; i++) tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 1, 0, 1);
    n_cmp++;
    if (msb_valid !== 1'b0 || msb_level !== 3'd0 || msb_ovf !== 1'b0 || msb_data !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mid: got valid=%b level=%0d ovf=%b data=%h, want 0/0/0/00",
               msb_valid, msb_level, msb_ovf, msb_data);
    end
    send_byte(8'h96, 0);
    n_cmp++;
    if (msb_data !== 8'h96 || lsb_data !== 8'h69 || msb_level !== 3'd1) begin
      n_bad++;
      $display("FAIL reset_fresh_word: got msb=%h lsb=%h level=%0d, want 96/69/1", msb_data, lsb_data, msb_level);
    end
    tick(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    logic [7:0] ed;
    bit         ev;
    int         el;
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 15) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 1), $urandom_range(0, 299) == 0);
      ev = (mq.size() != 0);
      el = mq.size();
      ed = ev ? mq[0] : 8'h00;
      n_cmp++;
      if (lsb_data !== ed || lsb_valid !== ev || lsb_level !== el[2:0] || lsb_ovf !== movf) begin
        n_bad++;
        $display("FAIL rand_lsb cyc %0d: got %h/%b/%0d/%b, want %h/%b/%0d/%b",
                 c, lsb_data, lsb_valid, lsb_level, lsb_ovf, ed, ev, el, movf);
      end
      n_cmp++;
      if (msb_data !== rev8(ed) || msb_valid !== ev || msb_level !== el[2:0] || msb_ovf !== movf) begin
        n_bad++;
        $display("FAIL rand_msb cyc %0d: got %h/%b/%0d/%b, want %h/%b/%0d/%b",
                 c, msb_data, msb_valid, msb_level, msb_ovf, rev8(ed), ev, el, movf);
      end
    end
  endtask

  initial begin
    reset = 1; bit_in = 0; bit_valid = 0; frame_start = 0; flush = 0; out_ready = 0;
    movf = 0;
    test_reset();
    test_a5();
    test_gaps();
    test_flush();
    test_overflow();
    test_full_pop_and_frame();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
